// File: rtl/wb_init_pkg.sv
// Shared types and bus constants for the single-outstanding Wishbone classic initiator.
package wb_init_pkg;

    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_SELW = 4;

    localparam logic [WB_DW-1:0] RSP_DAT_ABORT = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_e;

endpackage

// File: rtl/wb_lat_timer.sv
// Clear/enable latency counter with a terminal-count flag for the stb-high cycle that would reach TIMEOUT.
module wb_lat_timer #(
    parameter int unsigned LAT_W   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [LAT_W-1:0] count_o,
    output logic             tc_o
);

    logic [LAT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // tc marks the cycle whose edge would bring the count to TIMEOUT.
    assign tc_o    = (count_q == LAT_W'(TIMEOUT - 1));
    assign count_o = count_q;

endmodule

// File: rtl/wb_master_initiator.sv
// Single-outstanding Wishbone classic initiator: one command in, one WB cycle, one response out.
module wb_master_initiator
    import wb_init_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned LAT_W   = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_SELW-1:0]  cmd_sel,
    input  logic [WB_AW-1:0]    cmd_adr,
    input  logic [WB_DW-1:0]    cmd_dat,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SELW-1:0]  wbm_sel_o,
    output logic [WB_AW-1:0]    wbm_adr_o,
    output logic [WB_DW-1:0]    wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DW-1:0]    wbm_dat_i,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DW-1:0]    rsp_dat,
    output logic                rsp_timeout,
    output logic [LAT_W-1:0]    rsp_latency
);

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [WB_SELW-1:0]  sel_q, sel_d;
    logic [WB_AW-1:0]    adr_q, adr_d;
    logic [WB_DW-1:0]    dat_q, dat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WB_DW-1:0]    rsp_dat_q, rsp_dat_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [LAT_W-1:0]    rsp_latency_q, rsp_latency_d;

    logic                tmr_clr, tmr_en, tmr_tc;
    logic [LAT_W-1:0]    tmr_count;

    wb_lat_timer #(
        .LAT_W   (LAT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .count_o (tmr_count),
        .tc_o    (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        sel_d         = sel_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_dat_d     = rsp_dat_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_latency_d = rsp_latency_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = cmd_we;
                    sel_d       = cmd_sel;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                    tmr_clr     = 1'b1;
                    state_d     = BUS;
                end
            end
            BUS: begin
                tmr_en = 1'b1;
                // Ack is tested first so an ack on the terminal-count edge still completes normally.
                if (wbm_ack_i) begin
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    rsp_dat_d     = we_q ? RSP_DAT_ABORT : wbm_dat_i;
                    rsp_timeout_d = 1'b0;
                    rsp_latency_d = tmr_count + 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (tmr_tc) begin
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    rsp_dat_d     = RSP_DAT_ABORT;
                    rsp_timeout_d = 1'b1;
                    rsp_latency_d = LAT_W'(TIMEOUT);
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            adr_q         <= '0;
            dat_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_latency_q <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            sel_q         <= sel_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_dat_q     <= rsp_dat_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_latency_q <= rsp_latency_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_dat     = rsp_dat_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_latency = rsp_latency_q;

endmodule

// File: tb/tb_wb_master_initiator.sv
// Randomized bench for wb_master_initiator with a delayed-ack responder and a transaction-level reference model.
module tb_wb_master_initiator;

    localparam int unsigned TO = 13;
    localparam int unsigned LW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_dat;
    logic [LW-1:0] rsp_latency;

    always #5 clk = ~clk;

    wb_master_initiator #(.TIMEOUT(TO), .LAT_W(LW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_sel     (cmd_sel),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_timeout (rsp_timeout),
        .rsp_latency (rsp_latency)
    );

    // Responder: acks on the resp_d-th stb-high edge (0 = never), 16-word memory.
    int unsigned resp_d  = 0;
    int unsigned stb_cnt = 0;
    logic        spur_ack = 1'b0;
    logic [31:0] rmem [16] = '{default: '0};

    always_comb wbm_ack_i = spur_ack || (wbm_cyc_o && wbm_stb_o && resp_d != 0 && stb_cnt == resp_d - 1);
    always_comb wbm_dat_i = rmem[wbm_adr_o[5:2]];

    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o) stb_cnt <= stb_cnt + 1;
        else                        stb_cnt <= 0;
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o)
            for (int b = 0; b < 4; b++)
                if (wbm_sel_o[b]) rmem[wbm_adr_o[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
    end

    // Reference model state and current expectations.
    logic [31:0] mmem [16] = '{default: '0};
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat, e_rdat;
    logic        e_to;
    logic [LW-1:0] e_lat;
    logic        in_txn = 1'b0;
    logic        chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready_only_idle", cmd_ready, !(wbm_cyc_o || rsp_valid));
            chk("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
            if (wbm_cyc_o) begin
                chk("no_unrequested_cycle", in_txn, 1'b1);
                chk("wbm_we", wbm_we_o, e_we);
                chk("wbm_sel", wbm_sel_o, e_sel);
                chk("wbm_adr", wbm_adr_o, e_adr);
                chk("wbm_dat", wbm_dat_o, e_dat);
            end
            if (rsp_valid) begin
                chk("rsp_dat", rsp_dat, e_rdat);
                chk("rsp_timeout", rsp_timeout, e_to);
                chk("rsp_latency", rsp_latency, e_lat);
            end
        end
    end

    task automatic garbage_cmd();
        cmd_we  = 1'($urandom);
        cmd_sel = 4'($urandom);
        cmd_adr = $urandom;
        cmd_dat = $urandom;
    endtask

    task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input int unsigned d, input int unsigned bp,
                           input bit spur, output logic [31:0] g_dat, output logic g_to,
                           output logic [LW-1:0] g_lat);
        int unsigned idx = int'(adr[5:2]);
        bit acked = (d >= 1 && d <= TO);
        int unsigned n;
        e_we = we; e_sel = sel; e_adr = adr; e_dat = dat;
        e_lat  = acked ? LW'(d) : LW'(TO);
        e_to   = !acked;
        e_rdat = (acked && !we) ? mmem[idx] : 32'h0;
        if (acked && we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) mmem[idx][8*b +: 8] = dat[8*b +: 8];
        resp_d = d;
        in_txn = 1'b1;
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_wait_bound", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        garbage_cmd();
        chk("cyc_after_accept", wbm_cyc_o, 1'b1);
        n = 0;
        while (wbm_cyc_o && n < TO + 5) begin @(posedge clk); #1; n++; end
        chk("stb_high_edges", n, e_lat);
        in_txn = 1'b0;
        chk("rsp_valid_set", rsp_valid, 1'b1);
        g_dat = rsp_dat; g_to = rsp_timeout; g_lat = rsp_latency;
        for (int i = 0; i < int'(bp); i++) begin
            cmd_valid = 1'b1;
            garbage_cmd();
            spur_ack = spur && (i % 2 == 0);
            @(posedge clk); #1;
            chk("rsp_held", rsp_valid, 1'b1);
        end
        spur_ack  = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = (bp > 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("rsp_valid_clear", rsp_valid, 1'b0);
        chk("cmd_ready_back", cmd_ready, 1'b1);
        chk("no_cycle_on_rsp_edge", wbm_cyc_o, 1'b0);
        if (spur) begin
            spur_ack = 1'b1;
            @(posedge clk); #1;
            spur_ack = 1'b0;
            chk("idle_spur_cyc", wbm_cyc_o, 1'b0);
            chk("idle_spur_rsp", rsp_valid, 1'b0);
        end
    endtask

    logic [31:0]   g_dat;
    logic          g_to;
    logic [LW-1:0] g_lat;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_cyc", wbm_cyc_o, 1'b0);
        chk("rst_stb", wbm_stb_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_outputs_zero", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat, rsp_timeout, rsp_latency}, '0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_txn(1'b1, 4'hF, 32'h3800_0000, 32'hA5A5_1234, 3, 0, 0, g_dat, g_to, g_lat);
        chk("wr3_lat", g_lat, 3);
        chk("wr3_dat", g_dat, 0);
        chk("wr3_to", g_to, 0);

        run_txn(1'b1, 4'hF, 32'h3800_0010, 32'hCAFE_F00D, 2, 0, 0, g_dat, g_to, g_lat);
        run_txn(1'b0, 4'hF, 32'h3800_0010, 32'h0, 1, 0, 0, g_dat, g_to, g_lat);
        chk("rd_comb_dat", g_dat, 32'hCAFE_F00D);
        chk("rd_comb_lat", g_lat, 1);

        run_txn(1'b0, 4'hF, 32'h3800_0000, 32'h0, 12, 0, 0, g_dat, g_to, g_lat);
        chk("rd_bram_dat", g_dat, 32'hA5A5_1234);
        chk("rd_bram_lat", g_lat, 12);

        run_txn(1'b0, 4'hF, 32'h3800_0004, 32'h0, 0, 0, 0, g_dat, g_to, g_lat);
        chk("timeout_flag", g_to, 1);
        chk("timeout_lat", g_lat, TO);
        chk("timeout_dat", g_dat, 0);

        run_txn(1'b0, 4'hF, 32'h3800_0010, 32'h0, TO, 0, 0, g_dat, g_to, g_lat);
        chk("ack_at_tc_flag", g_to, 0);
        chk("ack_at_tc_dat", g_dat, 32'hCAFE_F00D);
        chk("ack_at_tc_lat", g_lat, TO);

        run_txn(1'b0, 4'hF, 32'h3800_0000, 32'h0, 2, 5, 1, g_dat, g_to, g_lat);
        chk("bp_dat", g_dat, 32'hA5A5_1234);

        // Reset mid-BUS with a responder that never acks.
        resp_d = 0;
        e_we = 1'b1; e_sel = 4'h3; e_adr = 32'h3800_0020; e_dat = 32'h1111_2222;
        in_txn = 1'b1;
        cmd_valid = 1'b1; cmd_we = e_we; cmd_sel = e_sel; cmd_adr = e_adr; cmd_dat = e_dat;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_cyc", wbm_cyc_o, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_txn = 1'b0;
        chk("mid_rst_cyc", wbm_cyc_o, 1'b0);
        chk("mid_rst_stb", wbm_stb_o, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < int'(TO) + 2; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            a = 32'h3800_0000 | 32'($urandom_range(0, 15) << 2);
            run_txn(1'($urandom), 4'($urandom), a, $urandom, $urandom_range(0, TO + 2),
                    $urandom_range(0, 3), ($urandom % 4) == 0, g_dat, g_to, g_lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
